// File: rtl/irqctrl.sv
// Interrupt request controller: synchronises IRQ/NMI pins, latches NMI edges and
// arbitrates reset > NMI > IRQ at instruction boundaries to force a BRK fetch.
module irqctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       irqN,
    input  logic       nmiN,
    input  logic       iFlag,
    input  logic       rCyc,
    input  logic [2:0] cycle,
    output logic       irq,
    output logic [1:0] vecSel,
    output logic       intSvc
);

    typedef enum logic [1:0] {IDLE, ARMED, SERVICE} state_t;

    localparam logic [1:0] VEC_RST = 2'b00;
    localparam logic [1:0] VEC_NMI = 2'b01;
    localparam logic [1:0] VEC_IRQ = 2'b10;

    state_t                 state, state_d;
    logic [SYNC_STAGES-1:0] irq_sync, nmi_sync;
    logic                   nmi_old, nmi_pend, nmi_pend_d;
    logic                   irq_d, svc_d, take_nmi;
    logic [1:0]             vec_d;
    logic                   irq_req, nmi_edge;

    assign irq_req  = ~irq_sync[SYNC_STAGES-1] & ~iFlag;
    assign nmi_edge = nmi_old & ~nmi_sync[SYNC_STAGES-1];
    // A fresh edge wins over the clear from arming, so it is not lost.
    assign nmi_pend_d = nmi_edge | (nmi_pend & ~take_nmi);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_sync <= '1;
            nmi_sync <= '1;
            nmi_old  <= 1'b1;
            nmi_pend <= 1'b0;
            state    <= ARMED;
            irq      <= 1'b1;
            vecSel   <= VEC_RST;
            intSvc   <= 1'b0;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], irqN};
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmiN};
            nmi_old  <= nmi_sync[SYNC_STAGES-1];
            nmi_pend <= nmi_pend_d;
            state    <= state_d;
            irq      <= irq_d;
            vecSel   <= vec_d;
            intSvc   <= svc_d;
        end
    end

    always_comb begin
        state_d  = state;
        irq_d    = irq;
        vec_d    = vecSel;
        svc_d    = intSvc;
        take_nmi = 1'b0;
        case (state)
            IDLE, SERVICE: begin
                if (rCyc) begin
                    if (nmi_pend) begin
                        state_d  = ARMED;
                        irq_d    = 1'b1;
                        vec_d    = VEC_NMI;
                        take_nmi = 1'b1;
                    end else if (irq_req) begin
                        state_d = ARMED;
                        irq_d   = 1'b1;
                        vec_d   = VEC_IRQ;
                    end else begin
                        state_d = IDLE;
                        svc_d   = 1'b0;
                    end
                end
            end
            ARMED: begin
                // cycle 1 means the forced opcode fetch has been latched
                if (cycle == 3'b001) begin
                    state_d = SERVICE;
                    irq_d   = 1'b0;
                    svc_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_irqctrl.sv
// Directed bench for irqctrl: a table of per-clock vectors plus hand sequences
// for the NMI edge/clear collision and asynchronous reset mid-service.
module tb_irqctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       irqN, nmiN, iFlag, rCyc;
    logic [2:0] cycle;
    logic       irq, intSvc;
    logic [1:0] vecSel;

    int n_tests = 0;
    int n_fail  = 0;

    irqctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .irqN(irqN), .nmiN(nmiN), .iFlag(iFlag),
        .rCyc(rCyc), .cycle(cycle), .irq(irq), .vecSel(vecSel), .intSvc(intSvc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rc, in, nn, fl;
        logic [2:0] cy;
        logic       e_irq;
        logic [1:0] e_vec;
        logic       e_svc, svc_x, e_pend;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(string name, logic rc, logic in, logic nn, logic fl,
                                logic [2:0] cy, logic e_irq, logic [1:0] e_vec,
                                logic e_svc, logic svc_x, logic e_pend);
        vec_t v;
        v.name = name; v.rc = rc; v.in = in; v.nn = nn; v.fl = fl; v.cy = cy;
        v.e_irq = e_irq; v.e_vec = e_vec; v.e_svc = e_svc; v.svc_x = svc_x; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(string name, logic e_irq, logic [1:0] e_vec, logic e_svc,
                           logic svc_x, logic e_pend);
        chk({name, ".irq"}, {7'd0, irq}, {7'd0, e_irq});
        chk({name, ".vecSel"}, {6'd0, vecSel}, {6'd0, e_vec});
        if (!svc_x) chk({name, ".intSvc"}, {7'd0, intSvc}, {7'd0, e_svc});
        chk({name, ".nmiPend"}, {7'd0, dut.nmi_pend}, {7'd0, e_pend});
    endtask

    // Drive inputs just after a falling edge, take one rising edge, land on the next falling edge.
    task automatic tick(logic rc, logic in, logic nn, logic fl, logic [2:0] cy);
        rCyc = rc; irqN = in; nmiN = nn; iFlag = fl; cycle = cy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(int n, logic nn);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, nn, 1'b1, 3'd0);
    endtask

    initial begin
        // name, rCyc, irqN, nmiN, iFlag, cycle | irq, vecSel, intSvc, svc_dontcare, nmiPend
        tv.push_back(mk("rst_hold_armed", 0,1,1,1,3'd0, 1,2'b00,0,0,0));
        tv.push_back(mk("rst_fetch",      0,1,1,1,3'd1, 0,2'b00,1,0,0));
        tv.push_back(mk("rst_end",        1,1,1,1,3'd0, 0,2'b00,0,0,0));
        tv.push_back(mk("irq_sync0",      0,0,1,1,3'd0, 0,2'b00,0,0,0));
        tv.push_back(mk("irq_sync1",      0,0,1,1,3'd0, 0,2'b00,0,0,0));
        tv.push_back(mk("irq_masked",     1,0,1,1,3'd0, 0,2'b00,0,0,0));
        tv.push_back(mk("irq_unmasked",   1,0,1,0,3'd0, 1,2'b10,0,0,0));
        tv.push_back(mk("irq_fetch",      0,0,1,0,3'd1, 0,2'b10,1,0,0));
        tv.push_back(mk("irq_rel0",       0,1,1,1,3'd0, 0,2'b10,1,0,0));
        tv.push_back(mk("irq_rel1",       0,1,1,1,3'd0, 0,2'b10,1,0,0));
        tv.push_back(mk("irq_end",        1,1,1,1,3'd0, 0,2'b10,0,0,0));
        tv.push_back(mk("nmi_lat1",       0,1,0,1,3'd0, 0,2'b10,0,0,0));
        tv.push_back(mk("nmi_lat2",       0,1,0,1,3'd0, 0,2'b10,0,0,0));
        tv.push_back(mk("nmi_lat3",       0,1,0,1,3'd0, 0,2'b10,0,0,1));
        tv.push_back(mk("nmi_arm",        1,1,0,1,3'd0, 1,2'b01,0,0,0));
        tv.push_back(mk("nmi_fetch",      0,1,0,1,3'd1, 0,2'b01,1,0,0));
        tv.push_back(mk("nmi_end",        1,1,0,1,3'd0, 0,2'b01,0,0,0));
        tv.push_back(mk("nmi_hi0",        0,1,1,1,3'd0, 0,2'b01,0,0,0));
        tv.push_back(mk("nmi_hi1",        0,1,1,1,3'd0, 0,2'b01,0,0,0));
        tv.push_back(mk("nmi_hi2",        0,1,1,1,3'd0, 0,2'b01,0,0,0));
        tv.push_back(mk("pri_lo0",        0,0,0,0,3'd0, 0,2'b01,0,0,0));
        tv.push_back(mk("pri_lo1",        0,0,0,0,3'd0, 0,2'b01,0,0,0));
        tv.push_back(mk("pri_pend",       0,0,0,0,3'd0, 0,2'b01,0,0,1));
        tv.push_back(mk("pri_nmi_wins",   1,0,0,0,3'd0, 1,2'b01,0,0,0));
        tv.push_back(mk("armed_rcyc_ign", 1,0,0,0,3'd0, 1,2'b01,0,0,0));
        tv.push_back(mk("pri_fetch",      0,0,0,0,3'd1, 0,2'b01,1,0,0));
        tv.push_back(mk("pri_chain_irq",  1,0,0,0,3'd0, 1,2'b10,1,1,0));
        tv.push_back(mk("chain_fetch",    0,1,1,1,3'd1, 0,2'b10,1,0,0));
        tv.push_back(mk("chain_end",      1,1,1,1,3'd0, 0,2'b10,0,0,0));

        rst = 1'b0; rCyc = 1'b0; irqN = 1'b1; nmiN = 1'b1; iFlag = 1'b1; cycle = 3'd0;
        repeat (3) @(negedge clk);
        chk_out("reset", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        foreach (tv[i]) begin
            tick(tv[i].rc, tv[i].in, tv[i].nn, tv[i].fl, tv[i].cy);
            chk_out(tv[i].name, tv[i].e_irq, tv[i].e_vec, tv[i].e_svc, tv[i].svc_x, tv[i].e_pend);
        end

        // NMI edge lands on the same edge that arms a previously pending NMI
        idle(2, 1'b1);
        idle(3, 1'b0);
        chk_out("col_first_pend", 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);
        idle(2, 1'b0);
        chk_out("col_pre", 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
        chk_out("col_arm_keeps_pend", 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
        chk_out("col_fetch", 1'b0, 2'b01, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
        chk_out("col_rearm_nmi", 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
        chk_out("col_fetch2", 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);

        // NMI edge during SERVICE, then asynchronous reset between edges
        idle(3, 1'b1);
        idle(3, 1'b0);
        chk_out("svc_nmi_pend", 1'b0, 2'b01, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1 chk_out("async_rst", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(3, 1'b1);
        chk_out("post_rst_armed", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
